// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: turns FIFO RAM reads into an AXI-Stream master stream through a 2-entry head/skid buffer.
// Ports: clk, rstn (sync, active-low), i_rempty (FIFO empty flag), o_ren (read request),
//   i_ram_ren (qualified RAM read), i_rdata (RAM data, one cycle after i_ram_ren),
//   m_tvalid / m_tready / m_tdata (AXI-Stream master).
// Macro FIFO_RD_CTRL_STATS_EN adds o_beat_cnt, a wrapping 32-bit count of accepted beats.
module fifo_rd_ctrl #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_rempty,
  output logic          o_ren,
  input  logic          i_ram_ren,
  input  logic [DW-1:0] i_rdata,
  output logic          m_tvalid,
  input  logic          m_tready,
`ifdef FIFO_RD_CTRL_STATS_EN
  output logic [DW-1:0] m_tdata,
  output logic [31:0]   o_beat_cnt
`else
  output logic [DW-1:0] m_tdata
`endif
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t state, state_nx;
  logic inflight, pop, push, head_ld;
  logic [1:0] occ;
  logic [DW-1:0] head, skid;
  // the empty flag is already folded into i_ram_ren upstream, so requests need not look at it
  logic unused;
  assign unused = i_rempty;
  assign pop = m_tvalid & m_tready;
  assign push = inflight;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= EMPTY;
      inflight <= 1'b0;
    end else begin
      state <= state_nx;
      inflight <= i_ram_ren;
    end
  end
  // TWO never sees a push: o_ren stays low whenever the buffer plus the in-flight word is already full
  always_comb begin
    state_nx = state == EMPTY ? (push ? ONE : EMPTY)
             : state == ONE   ? (push && !pop ? TWO : !push && pop ? EMPTY : ONE)
             :                  (pop ? ONE : TWO);
  end
  always_comb begin
    m_tvalid = state != EMPTY;
    occ = state == TWO ? 2'd2 : state == ONE ? 2'd1 : 2'd0;
  end
  // combinational m_tready -> o_ren path: a pop this cycle frees the slot the new request will use
  assign o_ren = rstn && (3'(occ) + 3'(inflight) - 3'(pop)) < 3'd2;
  // skid only matters in TWO, which is entered by a push into ONE without a pop
  assign head_ld = state == TWO ? pop : push && (pop || state == EMPTY);
  always_ff @(posedge clk) begin
    if (head_ld) head <= state == TWO ? skid : i_rdata;
    if (push) skid <= i_rdata;
  end
  assign m_tdata = head;
`ifdef FIFO_RD_CTRL_STATS_EN
  always_ff @(posedge clk) o_beat_cnt <= !rstn ? '0 : o_beat_cnt + 32'(pop);
`endif
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: self-checking bench for fifo_rd_ctrl against a 16-deep FIFO RAM model and a word-order scoreboard.
module tb_fifo_rd_ctrl;
  logic clk, rstn, rempty, o_ren, ram_ren, m_tvalid, m_tready;
  logic [7:0] rdata, m_tdata;
  logic [7:0] mem [16];
  logic [4:0] wr_ptr, rd_ptr, fill;
  int issued, acc, total, bad;
  logic [7:0] exp_q [$];
`ifdef FIFO_RD_CTRL_STATS_EN
  logic [31:0] beat_cnt;
`endif

  fifo_rd_ctrl #(.DW(8)) dut (
    .clk(clk), .rstn(rstn), .i_rempty(rempty), .o_ren(o_ren), .i_ram_ren(ram_ren),
    .i_rdata(rdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
`ifdef FIFO_RD_CTRL_STATS_EN
    .m_tdata(m_tdata), .o_beat_cnt(beat_cnt)
`else
    .m_tdata(m_tdata)
`endif
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  assign fill = wr_ptr - rd_ptr;
  assign rempty = fill == 5'd0;
  assign ram_ren = o_ren & ~rempty;

  // read-pointer block + RAM: data registered one cycle after the qualified read
  always @(posedge clk) begin
    if (!rstn) begin
      rd_ptr <= '0;
      issued <= 0;
    end else if (ram_ren) begin
      rdata <= mem[rd_ptr[3:0]];
      rd_ptr <= rd_ptr + 5'd1;
      issued <= issued + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic push_word(input logic [7:0] d);
    mem[wr_ptr[3:0]] = d;
    wr_ptr = wr_ptr + 5'd1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 0;
    m_tready = 0;
    wr_ptr = '0;
    acc = 0;
    #1 chk("rst_ren", 32'(o_ren), 0);
    repeat (2) begin
      @(negedge clk);
      #1 chk("rst_valid", 32'(m_tvalid), 0);
      chk("rst_ren", 32'(o_ren), 0);
    end
    rstn = 1;
  endtask

  typedef struct {
    bit wr; logic [7:0] wd; bit rdy; bit v; logic [7:0] d; bit ren;
  } vec_t;
  vec_t tbl [6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, got, cyc;
    bit pv, pr, seen;
    logic [7:0] pd, w;
    total = 0; bad = 0;
    rstn = 0; m_tready = 0; wr_ptr = '0; acc = 0;
    tbl[0] = '{1, 8'h11, 1, 0, 8'h00, 1};
    tbl[1] = '{1, 8'h22, 1, 0, 8'h00, 1};
    tbl[2] = '{1, 8'h33, 1, 1, 8'h11, 1};
    tbl[3] = '{0, 8'h00, 1, 1, 8'h22, 1};
    tbl[4] = '{0, 8'h00, 1, 1, 8'h33, 1};
    tbl[5] = '{0, 8'h00, 1, 0, 8'h00, 1};
    do_reset();
    // idle with an empty FIFO: nothing read, nothing shown, request may stay high
    repeat (3) begin
      @(negedge clk);
      #1 chk("idle_valid", 32'(m_tvalid), 0);
      chk("idle_ren", 32'(o_ren), 1);
      chk("idle_issue", 32'(issued), 0);
    end
    // three words streamed with the sink always ready
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (tbl[i].wr) push_word(tbl[i].wd);
      m_tready = tbl[i].rdy;
      #1 chk("tbl_valid", 32'(m_tvalid), 32'(tbl[i].v));
      if (tbl[i].v) chk("tbl_data", 32'(m_tdata), 32'(tbl[i].d));
      chk("tbl_ren", 32'(o_ren), 32'(tbl[i].ren));
    end
    // backpressure: buffer fills, requests stop, head holds
    @(negedge clk);
    m_tready = 0;
    for (int i = 0; i < 8; i++) push_word(8'hA0 + 8'(i));
    repeat (4) @(negedge clk);
    #1 chk("bp_valid", 32'(m_tvalid), 1);
    chk("bp_data", 32'(m_tdata), 32'hA0);
    chk("bp_ren", 32'(o_ren), 0);
    chk("bp_issued", 32'(issued - 3), 2);
    @(negedge clk);
    #1 chk("bp_hold", 32'(m_tdata), 32'hA0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      m_tready = 1;
      #1 chk("burst_valid", 32'(m_tvalid), 1);
      chk("burst_data", 32'(m_tdata), 32'hA0 + 32'(i));
    end
    @(negedge clk);
    #1 chk("burst_end", 32'(m_tvalid), 0);
    // random backpressure over 1000 words, pointers wrap many times
    do_reset();
    exp_q.delete();
    sent = 0; got = 0; cyc = 0; pv = 0; pr = 0; pd = '0;
    while (got < 1000 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (sent < 1000 && !fill[4] && $urandom_range(0, 9) < 7) begin
        w = 8'($urandom);
        push_word(w);
        exp_q.push_back(w);
        sent++;
      end
      if (pv && !pr) begin
        chk("hold_valid", 32'(m_tvalid), 1);
        chk("hold_data", 32'(m_tdata), 32'(pd));
      end
      m_tready = 1'($urandom_range(0, 1));
      #1 chk("room", 32'(issued - acc <= 2), 1);
      if (m_tvalid && m_tready) begin
        chk("spurious", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) chk("order", 32'(m_tdata), 32'(exp_q.pop_front()));
        acc++;
        got++;
      end
      pv = m_tvalid; pr = m_tready; pd = m_tdata;
    end
    chk("rand_count", 32'(got), 1000);
    // reset while words are buffered and one is in flight
    @(negedge clk);
    m_tready = 0;
    for (int i = 0; i < 4; i++) push_word(8'hB0 + 8'(i));
    repeat (4) @(negedge clk);
    #1 chk("pre_rst_data", 32'(m_tdata), 32'hB0);
    @(negedge clk);
    m_tready = 1;
    #1 chk("pre_rst_ren", 32'(o_ren), 1);
    do_reset();
    repeat (3) begin
      @(negedge clk);
      #1 chk("post_rst_valid", 32'(m_tvalid), 0);
    end
    @(negedge clk);
    push_word(8'h5A);
    m_tready = 1;
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      #1 if (m_tvalid) begin
        seen = 1;
        chk("first_after_rst", 32'(m_tdata), 32'h5A);
      end
    end
    chk("first_seen", 32'(seen), 1);
    @(negedge clk);
    #1 chk("after_5a", 32'(m_tvalid), 0);
`ifdef FIFO_RD_CTRL_STATS_EN
    do_reset();
    @(negedge clk);
    #1 chk("cnt_rst", beat_cnt, 0);
    m_tready = 1;
    for (int i = 0; i < 5; i++) push_word(8'(i));
    repeat (10) @(negedge clk);
    #1 chk("cnt_5", beat_cnt, 5);
    force dut.o_beat_cnt = 32'hFFFF_FFFF;
    #1 release dut.o_beat_cnt;
    push_word(8'h77);
    repeat (5) @(negedge clk);
    #1 chk("cnt_wrap", beat_cnt, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
